// File: rtl/audio_position_poller_pkg.sv
// Shared definitions for the audio position poller.
//   poller_state_t : read-transaction state encoding
//   cnt_width()    : bit width of a counter that must hold values 0..max_value
package audio_position_poller_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_WAIT    = 2'd2,
        ST_CAPTURE = 2'd3
    } poller_state_t;

    function automatic int cnt_width(input int max_value);
        return (max_value < 1) ? 1 : $clog2(max_value + 1);
    endfunction

endpackage

// File: rtl/audio_position_poller_tick_gen.sv
// Free-running poll timer: counts 0..DIV-1 while enabled and flags the
// DIV-1 cycle. Dropping enable parks the count at 0 so a re-enable always
// waits a full DIV cycles before the first tick.
//   clk    : system clock
//   reset  : synchronous, active-high
//   enable : run the timer
//   tick   : high during the count == DIV-1 cycle
module poll_tick_gen
    import audio_position_poller_pkg::*;
#(
    parameter int DIV = 50000
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    output logic tick
);

    localparam int W = cnt_width(DIV - 1);

    logic [W-1:0] count;

    always_ff @(posedge clk) begin
        if (reset || !enable) begin
            count <= '0;
        end else if (count == W'(DIV - 1)) begin
            count <= '0;
        end else begin
            count <= count + W'(1);
        end
    end

    assign tick = enable && (count == W'(DIV - 1));

endmodule

// File: rtl/audio_position_poller.sv
// Avalon-MM read initiator that periodically samples the audio-position PIO
// register and republishes it to fabric logic with valid/changed strobes.
//   clk, reset        : system clock, synchronous active-high reset
//   enable            : run the automatic poll timer
//   poll_now          : one-cycle request for an immediate poll
//   avm_address/read  : Avalon-MM read request (address fixed at REG_ADDR)
//   avm_waitrequest   : slave stall
//   avm_readdata      : slave data, valid READ_LATENCY cycles after acceptance
//   position          : last successfully read value
//   position_valid    : one-cycle pulse when position updates
//   position_changed  : with position_valid, when the value differs (or first capture)
//   busy              : transaction in progress
//   timeout_err       : one-cycle pulse when a stalled read is abandoned
//
// state   | meaning
// IDLE    | no transaction; start one when a poll is pending or requested
// REQ     | avm_read asserted, waiting for waitrequest to drop (stall-limited)
// WAIT    | read accepted, counting down the slave read latency
// CAPTURE | position/valid/changed presented for one cycle
module audio_position_poller
    import audio_position_poller_pkg::*;
#(
    parameter int         POLL_DIV     = 50000,
    parameter int         READ_LATENCY = 1,
    parameter int         TIMEOUT      = 255,
    parameter logic [1:0] REG_ADDR     = 2'd0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        poll_now,
    output logic [1:0]  avm_address,
    output logic        avm_read,
    input  logic        avm_waitrequest,
    input  logic [31:0] avm_readdata,
    output logic [31:0] position,
    output logic        position_valid,
    output logic        position_changed,
    output logic        busy,
    output logic        timeout_err
);

    localparam int LAT_W   = cnt_width(READ_LATENCY - 1);
    localparam int STALL_W = cnt_width(TIMEOUT);

    poller_state_t      state, state_nxt;
    logic [LAT_W-1:0]   lat_cnt, lat_cnt_nxt;
    logic [STALL_W-1:0] stall_cnt, stall_cnt_nxt;
    logic               pending;
    logic               first_capture;
    logic               tick;
    logic               poll_req;
    logic               capture;
    logic               abort;

    poll_tick_gen #(
        .DIV (POLL_DIV)
    ) u_tick_gen (
        .clk    (clk),
        .reset  (reset),
        .enable (enable),
        .tick   (tick)
    );

    assign poll_req    = tick | poll_now;
    assign avm_address = REG_ADDR;

    always_comb begin
        state_nxt     = state;
        lat_cnt_nxt   = lat_cnt;
        stall_cnt_nxt = stall_cnt;
        capture       = 1'b0;
        abort         = 1'b0;
        case (state)
            ST_IDLE: begin
                if (pending || poll_req) begin
                    state_nxt     = ST_REQ;
                    stall_cnt_nxt = '0;
                end
            end
            ST_REQ: begin
                if (!avm_waitrequest) begin
                    state_nxt   = ST_WAIT;
                    lat_cnt_nxt = LAT_W'(READ_LATENCY - 1);
                end else if (stall_cnt == STALL_W'(TIMEOUT - 1)) begin
                    // This is the TIMEOUT-th stalled cycle: give up.
                    state_nxt = ST_IDLE;
                    abort     = 1'b1;
                end else begin
                    stall_cnt_nxt = stall_cnt + STALL_W'(1);
                end
            end
            ST_WAIT: begin
                // Readdata is sampled on the edge leaving WAIT so that the
                // registered outputs show it during CAPTURE.
                if (lat_cnt == '0) begin
                    state_nxt = ST_CAPTURE;
                    capture   = 1'b1;
                end else begin
                    lat_cnt_nxt = lat_cnt - LAT_W'(1);
                end
            end
            ST_CAPTURE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state            <= ST_IDLE;
            lat_cnt          <= '0;
            stall_cnt        <= '0;
            pending          <= 1'b0;
            first_capture    <= 1'b1;
            position         <= '0;
            position_valid   <= 1'b0;
            position_changed <= 1'b0;
            avm_read         <= 1'b0;
            busy             <= 1'b0;
            timeout_err      <= 1'b0;
        end else begin
            state     <= state_nxt;
            lat_cnt   <= lat_cnt_nxt;
            stall_cnt <= stall_cnt_nxt;
            // Requests arriving while busy collapse into a single pending poll.
            if (state == ST_IDLE && state_nxt == ST_REQ) begin
                pending <= 1'b0;
            end else if (poll_req) begin
                pending <= 1'b1;
            end
            avm_read         <= (state_nxt == ST_REQ);
            busy             <= (state_nxt != ST_IDLE);
            timeout_err      <= abort;
            position_valid   <= capture;
            position_changed <= capture && (first_capture || (avm_readdata != position));
            if (capture) begin
                position      <= avm_readdata;
                first_capture <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_audio_position_poller.sv
// Bench for audio_position_poller with POLL_DIV=8, READ_LATENCY=1, TIMEOUT=16.
// A registered PIO slave supplies readdata; a cycle-stamped transaction
// model predicts every output each cycle, and directed scenarios add
// hand-computed literal expectations.
module tb_audio_position_poller;

    localparam int         POLL_DIV     = 8;
    localparam int         READ_LATENCY = 1;
    localparam int         TIMEOUT      = 16;
    localparam logic [1:0] REG_ADDR     = 2'd0;
    localparam int         NEVER        = 2147483647;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        poll_now;
    logic [1:0]  avm_address;
    logic        avm_read;
    logic        avm_waitrequest;
    logic [31:0] avm_readdata = '0;
    logic [31:0] position;
    logic        position_valid;
    logic        position_changed;
    logic        busy;
    logic        timeout_err;
    logic [31:0] in_port;

    always #5 clk = ~clk;

    audio_position_poller #(
        .POLL_DIV     (POLL_DIV),
        .READ_LATENCY (READ_LATENCY),
        .TIMEOUT      (TIMEOUT),
        .REG_ADDR     (REG_ADDR)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .enable           (enable),
        .poll_now         (poll_now),
        .avm_address      (avm_address),
        .avm_read         (avm_read),
        .avm_waitrequest  (avm_waitrequest),
        .avm_readdata     (avm_readdata),
        .position         (position),
        .position_valid   (position_valid),
        .position_changed (position_changed),
        .busy             (busy),
        .timeout_err      (timeout_err)
    );

    // Audio-position PIO slave: register 0 returns in_port, registered.
    always @(posedge clk) begin
        if (avm_read && !avm_waitrequest)
            avm_readdata <= (avm_address == 2'd0) ? in_port : 32'h0;
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // ---------------- transaction model ----------------
    int          cyc = 0;
    bit          m_init = 0;
    bit          m_reading, m_pend, m_first;
    int          m_free_at, m_cap, m_stall, en_run;
    logic [31:0] m_pos, m_cap_val;
    bit          e_read, e_busy, e_valid, e_chg, e_terr;
    logic [31:0] e_pos;
    bit          s_tick, s_req, s_start, s_terr;

    int n_accepts = 0, n_read_cyc = 0, n_terr = 0, n_valid = 0, n_changed = 0;

    always @(negedge clk) begin
        if (m_init) begin
            check("avm_read",         32'(avm_read),         32'(e_read));
            check("busy",             32'(busy),             32'(e_busy));
            check("position_valid",   32'(position_valid),   32'(e_valid));
            check("position_changed", 32'(position_changed), 32'(e_chg));
            check("timeout_err",      32'(timeout_err),      32'(e_terr));
            check("position",         position,              e_pos);
            check("avm_address",      32'(avm_address),      32'(REG_ADDR));
        end
        if (!reset) begin
            if (avm_read && !avm_waitrequest) n_accepts++;
            if (avm_read) n_read_cyc++;
            if (timeout_err) n_terr++;
            if (position_valid) n_valid++;
            if (position_changed) n_changed++;
        end

        // Predict outputs for cycle cyc+1 from inputs seen in cycle cyc.
        if (reset) begin
            m_reading = 0; m_pend = 0; m_first = 1; m_free_at = cyc + 1;
            m_cap = -1; m_stall = 0; en_run = 0; m_pos = '0;
            e_read = 0; e_busy = 0; e_valid = 0; e_chg = 0; e_terr = 0; e_pos = '0;
            m_init = 1;
        end else if (m_init) begin
            s_tick  = enable && (en_run % POLL_DIV == POLL_DIV - 1);
            en_run  = enable ? en_run + 1 : 0;
            s_req   = s_tick || poll_now;
            s_start = 0;
            s_terr  = 0;
            if (m_reading) begin
                if (!avm_waitrequest) begin
                    m_reading = 0;
                    m_cap     = cyc + READ_LATENCY + 1;
                    m_free_at = m_cap + 1;
                    m_cap_val = in_port;
                end else begin
                    m_stall++;
                    if (m_stall == TIMEOUT) begin
                        m_reading = 0;
                        m_free_at = cyc + 1;
                        s_terr    = 1;
                    end
                end
            end else if (cyc >= m_free_at && (m_pend || s_req)) begin
                m_reading = 1; m_stall = 0; m_free_at = NEVER; s_start = 1;
            end
            m_pend = s_start ? 1'b0 : (m_pend || s_req);
            e_read  = m_reading;
            e_busy  = (cyc + 1) < m_free_at;
            e_valid = (cyc + 1) == m_cap;
            e_terr  = s_terr;
            if (e_valid) begin
                e_chg   = m_first || (m_cap_val != m_pos);
                m_pos   = m_cap_val;
                m_first = 0;
            end else begin
                e_chg = 0;
            end
            e_pos = m_pos;
        end
        cyc++;
    end

    // ---------------- stimulus ----------------
    task automatic cyc_n(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    int a0, r0, t0, v0, c0, first_k;

    initial begin
        reset = 1; enable = 0; poll_now = 0; avm_waitrequest = 0; in_port = '0;
        cyc_n(3);
        reset = 0;
        cyc_n(3);
        check("rst_position", position, 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_read", 32'(avm_read), 32'h0);

        // Single poll: read in N+1, result in N+3.
        in_port = 32'h0000_1234;
        poll_now = 1; cyc_n(1); poll_now = 0;
        check("p1_read_n1", 32'(avm_read), 32'h1);
        cyc_n(1);
        check("p1_read_n2", 32'(avm_read), 32'h0);
        cyc_n(1);
        check("p1_position", position, 32'h0000_1234);
        check("p1_valid", 32'(position_valid), 32'h1);
        check("p1_changed", 32'(position_changed), 32'h1);
        cyc_n(3);

        // Two polls of an unchanged value.
        in_port = 32'hABCD_0000;
        poll_now = 1; cyc_n(1); poll_now = 0; cyc_n(5);
        poll_now = 1; cyc_n(1); poll_now = 0; cyc_n(2);
        check("p2_valid", 32'(position_valid), 32'h1);
        check("p2_changed", 32'(position_changed), 32'h0);
        check("p2_position", position, 32'hABCD_0000);
        cyc_n(3);

        // Timer: 32 enabled cycles give 4 reads; disabled gives none.
        a0 = n_accepts;
        enable = 1;
        for (int i = 0; i < 32; i++) begin
            in_port = 32'h100 + 32'(i);
            cyc_n(1);
        end
        enable = 0;
        cyc_n(8);
        check("tmr_reads_enabled", 32'(n_accepts - a0), 32'd4);
        a0 = n_accepts;
        cyc_n(24);
        check("tmr_reads_disabled", 32'(n_accepts - a0), 32'd0);
        enable = 1;
        first_k = 0;
        for (int k = 1; k <= 12; k++) begin
            cyc_n(1);
            if (avm_read && first_k == 0) first_k = k;
        end
        check("tmr_first_read_after_reenable", 32'(first_k), 32'd8);
        enable = 0;
        cyc_n(6);

        // Waitrequest for 3 cycles: avm_read held 4 cycles.
        in_port = 32'h5555_AAAA;
        r0 = n_read_cyc;
        avm_waitrequest = 1; poll_now = 1; cyc_n(1); poll_now = 0;
        cyc_n(3);
        avm_waitrequest = 0;
        cyc_n(8);
        check("stall3_read_cycles", 32'(n_read_cyc - r0), 32'd4);
        check("stall3_position", position, 32'h5555_AAAA);

        // Stuck bus: abort after 16 stalled cycles.
        in_port = 32'h7777_7777;
        r0 = n_read_cyc; t0 = n_terr;
        avm_waitrequest = 1; poll_now = 1; cyc_n(1); poll_now = 0;
        cyc_n(16);
        check("to_err", 32'(timeout_err), 32'h1);
        check("to_busy", 32'(busy), 32'h0);
        check("to_read", 32'(avm_read), 32'h0);
        check("to_position", position, 32'h5555_AAAA);
        avm_waitrequest = 0;
        cyc_n(4);
        check("to_err_pulses", 32'(n_terr - t0), 32'd1);
        check("to_read_cycles", 32'(n_read_cyc - r0), 32'd16);

        // Tick and poll_now while busy collapse into one extra read.
        in_port = 32'h0000_2222;
        a0 = n_accepts;
        enable = 1; cyc_n(6);
        poll_now = 1; cyc_n(1); poll_now = 0;
        cyc_n(1);
        poll_now = 1; enable = 0; cyc_n(1); poll_now = 0;
        cyc_n(12);
        check("collapse_reads", 32'(n_accepts - a0), 32'd2);

        // Reset during WAIT, then a first capture of value 0.
        in_port = 32'h0;
        v0 = n_valid;
        poll_now = 1; cyc_n(1); poll_now = 0;
        cyc_n(1);
        reset = 1; cyc_n(1); reset = 0;
        check("rw_valid", 32'(position_valid), 32'h0);
        check("rw_busy", 32'(busy), 32'h0);
        check("rw_position", position, 32'h0);
        cyc_n(4);
        check("rw_no_valid", 32'(n_valid - v0), 32'd0);
        c0 = n_changed;
        poll_now = 1; cyc_n(1); poll_now = 0;
        cyc_n(2);
        check("rw_first_valid", 32'(position_valid), 32'h1);
        check("rw_first_changed", 32'(position_changed), 32'h1);
        check("rw_first_position", position, 32'h0);
        cyc_n(3);
        check("rw_changed_count", 32'(n_changed - c0), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/audio_position_poller.md
# audio_position_poller

Avalon-MM read initiator that periodically samples the 32-bit audio-position PIO slave (register 0, readdata registered one cycle after address) and republishes the value to fabric logic as a registered word with valid and changed strobes. Sits between the audio PIO slave and the game/sprite logic that needs playback position without going through the Nios. Provides a free-running poll timer, an on-demand poll request, waitrequest handling, and a stuck-bus timeout.

## Interface
- POLL_DIV, 50000, clk cycles between automatic polls while enabled (≥ 4)
- READ_LATENCY, 1, cycles from read acceptance to valid readdata (1–4)
- TIMEOUT, 255, max cycles avm_read may be stalled by waitrequest before abort
- REG_ADDR, 0, word address driven on avm_address

- clk  in  1  system clock; the only clock
- reset  in  1  synchronous, active-high reset
- enable  in  1  enables the automatic poll timer
- poll_now  in  1  single-cycle request for an immediate poll
- avm_address  out  2  read address, constant REG_ADDR
- avm_read  out  1  read strobe
- avm_waitrequest  in  1  slave stall
- avm_readdata  in  32  slave read data
- position  out  32  last successfully read value
- position_valid  out  1  one-cycle pulse when position updates
- position_changed  out  1  one-cycle pulse, coincident with position_valid, when the new value differs from the previous one
- busy  out  1  high whenever state ≠ IDLE
- timeout_err  out  1  one-cycle pulse on stalled-read abort

## Operation
- States: IDLE, REQ, WAIT, CAPTURE.
- Poll timer: counts 0..POLL_DIV-1 while enable=1, tick on the count=POLL_DIV-1 cycle, then wraps to 0. enable=0 clears the counter to 0; no tick.
- pending flag: set by tick or poll_now; cleared on IDLE→REQ. Multiple requests while pending or busy collapse into one pending poll; none are queued beyond one.
- IDLE: if pending (or tick/poll_now this cycle) → REQ.
- REQ: avm_read=1. If avm_waitrequest=0 this cycle, read accepted → WAIT, latency counter loaded with READ_LATENCY-1. If stall counter reaches TIMEOUT → IDLE, avm_read drops, timeout_err pulses, position unchanged.
- WAIT: decrement; at 0 → CAPTURE. With READ_LATENCY=1, WAIT lasts one cycle.
- CAPTURE: position ← avm_readdata; position_valid=1; position_changed=1 if value ≠ old position or first capture since reset; → IDLE.
- avm_address always REG_ADDR; avm_read asserted only in REQ.
- enable deassert mid-transaction: in-flight read completes normally.
- Reset at any state: → IDLE, transaction abandoned, pending cleared.

## Timing
- Reset values: avm_read=0, position=0, position_valid=0, position_changed=0, busy=0, timeout_err=0, timer=0, first-capture flag set.
- poll_now at cycle N (IDLE, no stall): avm_read high in N+1, accepted N+1, readdata sampled at end of N+1+READ_LATENCY, position/position_valid visible in N+2+READ_LATENCY.
- Minimum poll-to-poll spacing: 3+READ_LATENCY cycles.
- Timeout: abort after exactly TIMEOUT stalled cycles in REQ; timeout_err in the following cycle, busy low that same cycle.
- All outputs registered.

## Structure
- Shared package: state enum, READ_LATENCY/TIMEOUT counter width helpers.
- Single module; the poll timer is a natural sub-module, poll_tick_gen (DIV parameter, enable, tick).
- Bench reuses the audio-position PIO slave model (readdata registered, address 0 gated).

## Test plan
- Reset then poll_now with slave in_port=0x0000_1234 → avm_read one cycle, position=0x1234, position_valid and position_changed pulse together, latency 3 cycles.
- Two consecutive polls with in_port unchanged 0xABCD_0000 → second poll gives position_valid=1, position_changed=0.
- enable=1, POLL_DIV=8, no poll_now → one read per 8 cycles; enable=0 → no reads, timer reads 0 on re-enable.
- waitrequest held 3 cycles → avm_read held 4 cycles, capture correct; held TIMEOUT(=16) cycles → timeout_err pulse, position unchanged, busy low.
- poll_now and tick both fire while busy → exactly one extra read follows completion.
- Reset asserted in WAIT → no position_valid, outputs at reset values next cycle, next poll behaves as first capture (position_changed=1 even for value 0).
